record_play_sequencer: RTL and testbench

RECORD_PLAY_SEQUENCER -- requirements
Module: record_play_sequencer

---
 rtl/record_play_sequencer_if.sv | 25 ++
 rtl/record_play_sequencer.sv | 178 +++++++++++++++++
 tb/tb_record_play_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/record_play_sequencer_if.sv
// Note RAM port bundle between the record/play sequencer and the note memory.
// The sequencer drives the address, write data and the two one-cycle strobes.
interface record_play_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 10
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_wdata,
    output mem_re
  );

  modport slave (
    input mem_addr,
    input mem_we,
    input mem_wdata,
    input mem_re
  );
endinterface

// File: rtl/record_play_sequencer.sv
// Record/playback sequencer for a note RAM.
// Recording writes one switch-bank note per tempo beat.
// Playback reads the recorded slots back on the beat and either finishes or
// wraps to slot 0. Every output is registered. The strobes are single-cycle
// pulses that are cleared by default on every edge.
module record_play_sequencer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   select,
  input  logic                   back,
  input  logic                   mode,
  input  logic                   loop_en,
  input  logic                   beat,
  input  logic [DATA_W-1:0]      note_in,
  record_play_sequencer_if.master mem,
  output logic [ADDR_W:0]        length,
  output logic [2:0]             state,
  output logic                   done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_REC  = 3'd2,
    ST_PLAY = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ZERO  = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LEN_FULL  = (ADDR_W+1)'(DEPTH);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic              we_r, we_s;
  logic              re_r, re_s;
  logic [ADDR_W:0]   length_r, length_s;
  logic              done_r, done_s;

  // Next-state and next-output decode; back outranks select, which outranks beat.
  always_comb begin
    state_s  = state_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    we_s     = 1'b0;
    re_s     = 1'b0;
    length_s = length_r;
    case (state_r)
      ST_IDLE: begin
        if (back) begin
          state_s = ST_IDLE;
        end else if (select) begin
          if (!mode) begin
            state_s  = ST_ARM;
            length_s = LEN_ZERO;
          end else if (length_r != LEN_ZERO) begin
            state_s = ST_PLAY;
            addr_s  = ADDR_ZERO;
            re_s    = 1'b1;
          end else begin
            // Nothing recorded: a playback request is ignored.
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (back) begin
          state_s  = ST_IDLE;
          length_s = LEN_ZERO;
        end else if (select) begin
          state_s = ST_DONE;
        end else if (beat) begin
          // The first beat both starts recording and captures slot 0.
          addr_s   = ADDR_ZERO;
          we_s     = 1'b1;
          wdata_s  = note_in;
          length_s = LEN_ONE;
          state_s  = (LEN_ONE == LEN_FULL) ? ST_DONE : ST_REC;
        end else begin
          state_s = ST_ARM;
        end
      end
      ST_REC: begin
        if (back) begin
          state_s  = ST_IDLE;
          length_s = LEN_ZERO;
        end else if (select) begin
          state_s = ST_DONE;
        end else if (beat) begin
          // Filling the last slot ends the recording, so the address never wraps.
          addr_s   = addr_r + ADDR_ONE;
          we_s     = 1'b1;
          wdata_s  = note_in;
          length_s = length_r + LEN_ONE;
          state_s  = ((length_r + LEN_ONE) == LEN_FULL) ? ST_DONE : ST_REC;
        end else begin
          state_s = ST_REC;
        end
      end
      ST_PLAY: begin
        if (back) begin
          state_s = ST_IDLE;
        end else if (select) begin
          state_s = ST_DONE;
        end else if (beat) begin
          if ({1'b0, addr_r} == (length_r - LEN_ONE)) begin
            if (loop_en) begin
              addr_s = ADDR_ZERO;
              re_s   = 1'b1;
            end else begin
              state_s = ST_DONE;
            end
          end else begin
            addr_s = addr_r + ADDR_ONE;
            re_s   = 1'b1;
          end
        end else begin
          state_s = ST_PLAY;
        end
      end
      ST_DONE: begin
        if (back || select) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        // Unused codes 5..7 recover to IDLE.
        state_s = ST_IDLE;
      end
    endcase
  end

  // done follows the state being entered so that it is registered like every other output.
  always_comb begin
    done_s = (state_s == ST_DONE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      addr_r   <= ADDR_ZERO;
      wdata_r  <= DATA_W'(0);
      we_r     <= 1'b0;
      re_r     <= 1'b0;
      length_r <= LEN_ZERO;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      we_r     <= we_s;
      re_r     <= re_s;
      length_r <= length_s;
      done_r   <= done_s;
    end
  end

  assign mem.mem_addr  = addr_r;
  assign mem.mem_we    = we_r;
  assign mem.mem_wdata = wdata_r;
  assign mem.mem_re    = re_r;
  assign length        = length_r;
  assign state         = state_r;
  assign done          = done_r;

endmodule

// File: tb/tb_record_play_sequencer.sv
// Directed bench for record_play_sequencer: a vector table covers record,
// one-shot playback and looped playback. Hand-written sequences cover the
// full-memory boundary, back racing beat, and an asynchronous reset during playback.
module tb_record_play_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       select, back, mode, loop_en, beat;
  logic [9:0] note_in;
  logic [6:0] length;
  logic [2:0] state;
  logic       done;

  int checks = 0;
  int passed = 0;

  record_play_sequencer_if #(.ADDR_W(6), .DATA_W(10)) mif ();

  record_play_sequencer #(.DEPTH(64), .ADDR_W(6), .DATA_W(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .select  (select),
    .back    (back),
    .mode    (mode),
    .loop_en (loop_en),
    .beat    (beat),
    .note_in (note_in),
    .mem     (mif),
    .length  (length),
    .state   (state),
    .done    (done)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       sel, bk, md, lp, bt;
    logic [9:0] note;
    logic [2:0] st;
    logic [5:0] addr;
    logic       we, re;
    logic [9:0] wd;
    logic [6:0] len;
    logic       dn;
  } vec_t;

  vec_t vecs [21];

  // Packed observation: {state, addr, we, re, wdata, length, done}
  function automatic logic [28:0] obs();
    return {state, mif.mem_addr, mif.mem_we, mif.mem_re, mif.mem_wdata, length, done};
  endfunction

  function automatic logic [28:0] pack(input logic [2:0] st, input logic [5:0] a,
                                       input logic we, input logic re,
                                       input logic [9:0] wd, input logic [6:0] len,
                                       input logic dn);
    return {st, a, we, re, wd, len, dn};
  endfunction

  task automatic chk(input string nm, input logic [28:0] act, input logic [28:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got st/addr/we/re/wd/len/done=%h, expected %h", nm, act, exp);
  endtask

  task automatic step(input logic s, input logic b, input logic m, input logic l,
                      input logic bt, input logic [9:0] n);
    @(negedge clk);
    select = s; back = b; mode = m; loop_en = l; beat = bt; note_in = n;
    @(posedge clk);
    #1;
    select = 1'b0; back = 1'b0; mode = 1'b0; loop_en = 1'b0; beat = 1'b0; note_in = 10'h000;
  endtask

  initial begin
    //           sel  bk   md   lp   bt    note     st    addr  we   re    wd       len   dn
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 10'h000, 3'd1, 6'd0, 1'b0,1'b0, 10'h000, 7'd0, 1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 10'h001, 3'd2, 6'd0, 1'b1,1'b0, 10'h001, 7'd1, 1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 10'h000, 3'd2, 6'd0, 1'b0,1'b0, 10'h001, 7'd1, 1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 10'h002, 3'd2, 6'd1, 1'b1,1'b0, 10'h002, 7'd2, 1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 10'h004, 3'd2, 6'd2, 1'b1,1'b0, 10'h004, 7'd3, 1'b0};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 10'h000, 3'd4, 6'd2, 1'b0,1'b0, 10'h004, 7'd3, 1'b1};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 10'h3FF, 3'd4, 6'd2, 1'b0,1'b0, 10'h004, 7'd3, 1'b1};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 10'h000, 3'd0, 6'd2, 1'b0,1'b0, 10'h004, 7'd3, 1'b0};
    vecs[8]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 10'h000, 3'd3, 6'd0, 1'b0,1'b1, 10'h004, 7'd3, 1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 10'h000, 3'd3, 6'd0, 1'b0,1'b0, 10'h004, 7'd3, 1'b0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 10'h000, 3'd3, 6'd1, 1'b0,1'b1, 10'h004, 7'd3, 1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 10'h000, 3'd3, 6'd2, 1'b0,1'b1, 10'h004, 7'd3, 1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 10'h000, 3'd4, 6'd2, 1'b0,1'b0, 10'h004, 7'd3, 1'b1};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 10'h000, 3'd0, 6'd2, 1'b0,1'b0, 10'h004, 7'd3, 1'b0};
    vecs[14] = '{1'b1,1'b0,1'b1,1'b1,1'b0, 10'h000, 3'd3, 6'd0, 1'b0,1'b1, 10'h004, 7'd3, 1'b0};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 10'h000, 3'd3, 6'd1, 1'b0,1'b1, 10'h004, 7'd3, 1'b0};
    vecs[16] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 10'h000, 3'd3, 6'd2, 1'b0,1'b1, 10'h004, 7'd3, 1'b0};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 10'h000, 3'd3, 6'd0, 1'b0,1'b1, 10'h004, 7'd3, 1'b0};
    vecs[18] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 10'h000, 3'd3, 6'd1, 1'b0,1'b1, 10'h004, 7'd3, 1'b0};
    vecs[19] = '{1'b1,1'b0,1'b0,1'b1,1'b1, 10'h000, 3'd4, 6'd1, 1'b0,1'b0, 10'h004, 7'd3, 1'b1};
    vecs[20] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 10'h000, 3'd0, 6'd1, 1'b0,1'b0, 10'h004, 7'd3, 1'b0};

    reset = 1'b1;
    select = 1'b0; back = 1'b0; mode = 1'b0; loop_en = 1'b0; beat = 1'b0; note_in = 10'h000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", obs(), pack(3'd0, 6'd0, 1'b0, 1'b0, 10'h000, 7'd0, 1'b0));
    @(negedge clk);
    reset = 1'b0;

    // Table: record 3 notes, one-shot play, looped play.
    for (int i = 0; i < 21; i++) begin
      step(vecs[i].sel, vecs[i].bk, vecs[i].md, vecs[i].lp, vecs[i].bt, vecs[i].note);
      chk($sformatf("vec%0d", i), obs(),
          pack(vecs[i].st, vecs[i].addr, vecs[i].we, vecs[i].re, vecs[i].wd, vecs[i].len, vecs[i].dn));
    end

    // Full memory: 64 beats fill every slot, DONE on the 64th write.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
    chk("full_arm", obs(), pack(3'd1, 6'd1, 1'b0, 1'b0, 10'h004, 7'd0, 1'b0));
    for (int i = 0; i < 63; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'(i));
    chk("full_63", obs(), pack(3'd2, 6'd62, 1'b1, 1'b0, 10'd62, 7'd63, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h3C0);
    chk("full_64", obs(), pack(3'd4, 6'd63, 1'b1, 1'b0, 10'h3C0, 7'd64, 1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h155);
    chk("full_65_nowrite", obs(), pack(3'd4, 6'd63, 1'b0, 1'b0, 10'h3C0, 7'd64, 1'b1));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
    chk("full_exit", obs(), pack(3'd0, 6'd63, 1'b0, 1'b0, 10'h3C0, 7'd64, 1'b0));

    // back racing beat during REC discards the recording without a write.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'(i + 16));
    chk("rec5", obs(), pack(3'd2, 6'd4, 1'b1, 1'b0, 10'd20, 7'd5, 1'b0));
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h2AA);
    chk("back_beat_rec", obs(), pack(3'd0, 6'd4, 1'b0, 1'b0, 10'd20, 7'd0, 1'b0));

    // Asynchronous reset during playback at address 7.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'(i + 100));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
    chk("play_at7", obs(), pack(3'd3, 6'd7, 1'b0, 1'b1, 10'd109, 7'd10, 1'b0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_reset", obs(), pack(3'd0, 6'd0, 1'b0, 1'b0, 10'h000, 7'd0, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'h000);
    chk("play_empty", obs(), pack(3'd0, 6'd0, 1'b0, 1'b0, 10'h000, 7'd0, 1'b0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
